limber_gnrl_rst_seq: RTL and testbench

- Reset release sequencer for the generic library.
- Takes a raw asynchronous reset and produces NR active-high reset outputs. All outputs assert together; they deassert one at a time in index order, with a programmable gap between releases.
- Deassertion is synchronised through one limber_gnrl_ffchain instance.
- Sits at the clock/reset root of a subsystem and orders the bring-up of its blocks (e.g. bus → core → peripherals).

---
 rtl/limber_gnrl_pkg.sv | 19 +
 rtl/limber_gnrl_ffchain.sv | 31 +++
 rtl/limber_gnrl_rst_seq.sv | 129 ++++++++++++
 tb/tb_limber_gnrl_rst_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/limber_gnrl_pkg.sv
// Shared definitions for the generic library: reset sequencer FSM encoding and limits.
// Build option LIMBER_RST_SEQ_SWRST_EN (used in limber_gnrl_rst_seq) enables the software reset request.
package limber_gnrl_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'b00,
    ST_GAP  = 2'b01,
    ST_REL  = 2'b10,
    ST_DONE = 2'b11
  } rst_seq_state_e;

  localparam int SYNC_DP_MIN = 2;

  // Index width that stays at least one bit wide for single-output sequencers.
  function automatic int idx_width(input int n);
    idx_width = (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/limber_gnrl_ffchain.sv
// Generic flop chain: DP register stages of width DW, cleared by rst_asyn.
// Used as a reset-deassertion synchroniser when si is tied high.
module limber_gnrl_ffchain #(
  parameter int DW = 1,
  parameter int DP = 2
) (
  input  logic          clk,
  input  logic          rst_asyn,
  input  logic [DW-1:0] si,
  output logic [DW-1:0] so
);

  logic [DW-1:0] stg_r [DP];

  // Shift chain: stage 0 samples si, each later stage samples its predecessor.
  always_ff @(posedge clk or posedge rst_asyn) begin
    if (rst_asyn) begin
      for (int i = 0; i < DP; i++) begin
        stg_r[i] <= {DW{1'b0}};
      end
    end else begin
      stg_r[0] <= si;
      for (int i = 1; i < DP; i++) begin
        stg_r[i] <= stg_r[i-1];
      end
    end
  end

  assign so = stg_r[DP-1];

endmodule

// File: rtl/limber_gnrl_rst_seq.sv
// Reset release sequencer: asserts NR resets together, releases them in index order with gap_cfg+2 spacing.
// Define LIMBER_RST_SEQ_SWRST_EN to let sw_rst_req restart the sequence without re-synchronising.
module limber_gnrl_rst_seq
  import limber_gnrl_pkg::*;
#(
  parameter int NR      = 4,
  parameter int SYNC_DP = 2,
  parameter int GAP_W   = 8
) (
  input  logic             clk,
  input  logic             rst_asyn,
  input  logic [GAP_W-1:0] gap_cfg,
  input  logic             sw_rst_req,
  output logic [NR-1:0]    rst_o,
  output logic             done_o
);

  localparam int IDX_W = idx_width(NR);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NR - 1);

  rst_seq_state_e   state_r, state_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic [GAP_W-1:0] cnt_r, cnt_nxt_s;
  logic [NR-1:0]    rst_r, rst_nxt_s;
  logic             done_r, done_nxt_s;
  logic             sync_rdy_s;
  logic             sw_rst_s;

`ifdef LIMBER_RST_SEQ_SWRST_EN
  assign sw_rst_s = sw_rst_req;
`else
  logic unused_sw_rst_s;
  assign unused_sw_rst_s = sw_rst_req;
  assign sw_rst_s        = 1'b0;
`endif

  limber_gnrl_ffchain #(
    .DW (1),
    .DP (SYNC_DP)
  ) u_sync (
    .clk      (clk),
    .rst_asyn (rst_asyn),
    .si       (1'b1),
    .so       (sync_rdy_s)
  );

  // State and output registers; rst_asyn forces every reset output high at once.
  always_ff @(posedge clk or posedge rst_asyn) begin
    if (rst_asyn) begin
      state_r <= ST_WAIT;
      idx_r   <= {IDX_W{1'b0}};
      cnt_r   <= {GAP_W{1'b0}};
      rst_r   <= {NR{1'b1}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      cnt_r   <= cnt_nxt_s;
      rst_r   <= rst_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Next-state logic; a software request overrides whatever the sequence is doing.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    cnt_nxt_s   = cnt_r;
    rst_nxt_s   = rst_r;
    done_nxt_s  = done_r;
    if (sw_rst_s) begin
      state_nxt_s = ST_WAIT;
      idx_nxt_s   = {IDX_W{1'b0}};
      cnt_nxt_s   = {GAP_W{1'b0}};
      rst_nxt_s   = {NR{1'b1}};
      done_nxt_s  = 1'b0;
    end else begin
      case (state_r)
        ST_WAIT: begin
          if (sync_rdy_s) begin
            state_nxt_s = ST_GAP;
            cnt_nxt_s   = gap_cfg;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_GAP: begin
          if (cnt_r == {GAP_W{1'b0}}) begin
            state_nxt_s = ST_REL;
          end else begin
            cnt_nxt_s = cnt_r - GAP_W'(1);
          end
        end
        ST_REL: begin
          for (int i = 0; i < NR; i++) begin
            if (IDX_W'(i) == idx_r) begin
              rst_nxt_s[i] = 1'b0;
            end else begin
              rst_nxt_s[i] = rst_r[i];
            end
          end
          if (idx_r == IDX_LAST) begin
            state_nxt_s = ST_DONE;
            done_nxt_s  = 1'b1;
          end else begin
            idx_nxt_s   = idx_r + IDX_W'(1);
            state_nxt_s = ST_GAP;
            cnt_nxt_s   = gap_cfg;
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_DONE;
        end
        default: begin
          // Unreachable encoding: fall back to a full re-assert.
          state_nxt_s = ST_WAIT;
          idx_nxt_s   = {IDX_W{1'b0}};
          cnt_nxt_s   = {GAP_W{1'b0}};
          rst_nxt_s   = {NR{1'b1}};
          done_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  assign rst_o  = rst_r;
  assign done_o = done_r;

endmodule

// File: tb/tb_limber_gnrl_rst_seq.sv
// Scoreboard bench for limber_gnrl_rst_seq (NR=4, SYNC_DP=2, GAP_W=8).
// Expectations follow LIMBER_RST_SEQ_SWRST_EN when the bench is built with it.
module tb_limber_gnrl_rst_seq;

  typedef struct {
    int         edge_n;
    logic [3:0] rst;
    logic       done;
  } exp_t;

  logic       clk;
  logic       rst_asyn;
  logic [7:0] gap_cfg;
  logic       sw_rst_req;
  logic [3:0] rst_o;
  logic       done_o;

  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  logic [3:0] rel_tbl [4] = '{4'hE, 4'hC, 4'h8, 4'h0};
  logic [3:0] prev_rst  = 4'hF;
  logic       prev_done = 1'b0;
  logic [3:0] model_rst  = 4'hF;
  logic       model_done = 1'b0;

  limber_gnrl_rst_seq #(
    .NR      (4),
    .SYNC_DP (2),
    .GAP_W   (8)
  ) dut (
    .clk        (clk),
    .rst_asyn   (rst_asyn),
    .gap_cfg    (gap_cfg),
    .sw_rst_req (sw_rst_req),
    .rst_o      (rst_o),
    .done_o     (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the outputs must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_o !== prev_rst || done_o !== prev_done) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: edge %0d got rst_o=%h done_o=%b, none expected", cyc, rst_o, done_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.edge_n != cyc || rst_o !== e.rst || done_o !== e.done) begin
          n_fail++;
          $display("FAIL sb_change: got edge %0d rst_o=%h done_o=%b, want edge %0d rst_o=%h done_o=%b",
                   cyc, rst_o, done_o, e.edge_n, e.rst, e.done);
        end
      end
      prev_rst  = rst_o;
      prev_done = done_o;
    end
  end

  task automatic push(input int e, input logic [3:0] r, input logic d);
    exp_t x;
    x.edge_n = e;
    x.rst    = r;
    x.done   = d;
    sb_q.push_back(x);
    model_rst  = r;
    model_done = d;
  endtask

  // Releases of bits 0..3 at base+first+i*sp, limited to edges <= base+upto.
  task automatic push_rel(input int base, input int first, input int sp, input int upto);
    for (int i = 0; i < 4; i++) begin
      if (first + i * sp <= upto) push(base + first + i * sp, rel_tbl[i], (i == 3));
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_edge(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Asserts rst_asyn just after a clock edge and checks the immediate, clockless effect.
  task automatic assert_rst();
    @(posedge clk);
    #1;
    rst_asyn = 1'b1;
    if (model_rst !== 4'hF || model_done !== 1'b0) push(cyc, 4'hF, 1'b0);
    #1;
    chk("async_rst_o", {4'h0, rst_o}, 8'h0F);
    chk("async_done_o", {7'h0, done_o}, 8'h00);
    repeat (3) @(posedge clk);
  endtask

  task automatic release_rst(output int base);
    @(negedge clk);
    base     = cyc;
    rst_asyn = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d expected changes never seen, want 0", name, sb_q.size());
      sb_q.delete();
    end
    repeat (6) @(posedge clk);
  endtask

  initial begin
    int base;
    int e;
    rst_asyn   = 1'b1;
    gap_cfg    = 8'd3;
    sw_rst_req = 1'b0;
    #2;
    chk("reset_rst_o", {4'h0, rst_o}, 8'h0F);
    chk("reset_done_o", {7'h0, done_o}, 8'h00);
    repeat (3) @(posedge clk);

    // gap 3: releases on edges 8,13,18,23
    release_rst(base);
    push_rel(base, 8, 5, 23);
    drain("gap3");
    chk("gap3_done_hold", {3'h0, done_o, rst_o}, 8'h10);

    // gap 0: releases on edges 5,7,9,11
    gap_cfg = 8'd0;
    assert_rst();
    release_rst(base);
    push_rel(base, 5, 2, 11);
    drain("gap0");

    // rst_asyn at edge 15 mid-sequence, then a clean gap-3 run
    gap_cfg = 8'd3;
    assert_rst();
    release_rst(base);
    push_rel(base, 8, 5, 15);
    wait_edge(base + 15);
    chk("mid_pre_rst_o", {4'h0, rst_o}, 8'h0C);
    rst_asyn = 1'b1;
    push(cyc, 4'hF, 1'b0);
    #1;
    chk("mid_async_rst_o", {4'h0, rst_o}, 8'h0F);
    chk("mid_async_done_o", {7'h0, done_o}, 8'h00);
    repeat (3) @(posedge clk);
    release_rst(base);
    push_rel(base, 8, 5, 23);
    drain("mid_restart");

    // software request while in DONE
    @(negedge clk);
    e = cyc + 1;
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
`ifdef LIMBER_RST_SEQ_SWRST_EN
    push(e, 4'hF, 1'b0);
    push_rel(e, 6, 5, 21);
    drain("sw_done");
`else
    repeat (5) @(posedge clk);
    #1;
    chk("sw_done_ignored", {3'h0, done_o, rst_o}, 8'h10);
    drain("sw_done");
`endif

    // software request at edge 15 (GAP after bit 1 released)
    assert_rst();
    release_rst(base);
    push_rel(base, 8, 5, 15);
    wait_edge(base + 14);
    sw_rst_req = 1'b1;
    wait_edge(base + 15);
    sw_rst_req = 1'b0;
`ifdef LIMBER_RST_SEQ_SWRST_EN
    push(base + 15, 4'hF, 1'b0);
    push_rel(base + 15, 6, 5, 21);
`else
    push_rel(base, 8, 5, 23);
    sb_q.delete(0);
    sb_q.delete(0);
`endif
    drain("sw_gap");
    chk("sw_gap_final", {3'h0, done_o, rst_o}, 8'h10);

    // gap_cfg 3 -> 1 during the first gap: releases on 8,11,14,17
    assert_rst();
    release_rst(base);
    push_rel(base, 8, 3, 17);
    wait_edge(base + 5);
    gap_cfg = 8'd1;
    drain("gap_change");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, want completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
